// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO receive path: default word width,
// counter sizing helper and the output-buffer state encoding.
package sipo_pkg;

  localparam int unsigned SIPO_DEFAULT_WIDTH = 32'd4;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  // Bit count range is 0..width-1; never let the counter collapse to zero bits.
  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned w;
    w = $clog2(width);
    if (w < 32'd1) begin
      w = 32'd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Serial shift register and bit counter; raises done combinationally on the
// edge-to-be that samples the last bit of a word, with word = completed value.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = SIPO_DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             shift_en,
  input  logic             clear,
  output logic [WIDTH-1:0] word,
  output logic             done,
  output logic             busy
);

  localparam int unsigned          CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 32'd1);

  logic [WIDTH-1:0] sreg_r;
  logic [WIDTH-1:0] sreg_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             last_s;

  // Next shift-register value and completion detect.
  always_comb begin
    sreg_nxt_s = sreg_r;
    if (MSB_FIRST) begin
      sreg_nxt_s = {sreg_r[WIDTH-2:0], in};
    end else begin
      sreg_nxt_s = {in, sreg_r[WIDTH-1:1]};
    end
    last_s = (cnt_r == CNT_LAST);
    done   = shift_en & ~clear & last_s;
  end

  assign word = sreg_nxt_s;
  assign busy = busy_r;

  // Shift register, bit counter and registered busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_r <= {WIDTH{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      busy_r <= 1'b0;
    end else if (clear) begin
      sreg_r <= {WIDTH{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      busy_r <= 1'b0;
    end else if (shift_en) begin
      sreg_r <= sreg_nxt_s;
      if (last_s) begin
        cnt_r  <= {CNT_W{1'b0}};
        busy_r <= 1'b0;
      end else begin
        cnt_r  <= cnt_r + CNT_W'(1);
        busy_r <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sipo_receiver.sv
// SIPO receiver top: shift core plus a one-word output holding register with
// valid/ready handshake and a sticky overrun flag for dropped words.
module sipo_receiver
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = SIPO_DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             shift_en,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
);

  buf_state_e       state_r;
  buf_state_e       state_nxt_s;
  logic [WIDTH-1:0] out_r;
  logic             out_valid_r;
  logic             overrun_r;
  logic [WIDTH-1:0] word_s;
  logic             done_s;
  logic             load_s;
  logic             ovr_set_s;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .shift_en (shift_en),
    .clear    (clear),
    .word     (word_s),
    .done     (done_s),
    .busy     (busy)
  );

  // Buffer next-state: a handshake frees the slot on the same edge a new word lands.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    ovr_set_s   = 1'b0;
    case (state_r)
      BUF_EMPTY: begin
        if (done_s) begin
          state_nxt_s = BUF_FULL;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (done_s && out_ready) begin
          state_nxt_s = BUF_FULL;
          load_s      = 1'b1;
        end else if (done_s) begin
          state_nxt_s = BUF_FULL;
          ovr_set_s   = 1'b1;
        end else if (out_ready) begin
          state_nxt_s = BUF_EMPTY;
        end else begin
          state_nxt_s = BUF_FULL;
        end
      end
      default: begin
        state_nxt_s = BUF_EMPTY;
      end
    endcase
  end

  // Holding register, valid flag and sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= BUF_EMPTY;
      out_r       <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= (state_nxt_s == BUF_FULL);
      if (load_s) begin
        out_r <= word_s;
      end
      if (clear) begin
        overrun_r <= 1'b0;
      end else if (ovr_set_s) begin
        overrun_r <= 1'b1;
      end
    end
  end

  assign out       = out_r;
  assign out_valid = out_valid_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_sipo_receiver.sv
// Scoreboard bench: an MSB-first and an LSB-first receiver share stimulus; a
// bit-list reference model queues expected words, a negedge monitor checks them.
module tb_sipo_receiver;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in = 1'b0;
  logic         shift_en = 1'b0;
  logic         clear = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_m, out_l;
  logic         valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;

  int checks = 0;
  int errors = 0;

  bit       bits[$];
  bit [W-1:0] q_m[$];
  bit [W-1:0] q_l[$];
  bit       m_valid = 1'b0;
  bit       m_ovr = 1'b0;

  always #5 clk = ~clk;

  sipo_receiver #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in(in), .shift_en(shift_en), .clear(clear),
    .out(out_m), .out_valid(valid_m), .out_ready(out_ready),
    .busy(busy_m), .overrun(ovr_m)
  );

  sipo_receiver #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in(in), .shift_en(shift_en), .clear(clear),
    .out(out_l), .out_valid(valid_l), .out_ready(out_ready),
    .busy(busy_l), .overrun(ovr_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bits collect into a list; a full list becomes a word.
  always @(posedge clk or posedge rst) begin
    bit hs, done;
    bit [W-1:0] wm, wl;
    if (rst) begin
      bits.delete();
      q_m.delete();
      q_l.delete();
      m_valid = 1'b0;
      m_ovr = 1'b0;
    end else begin
      hs = m_valid && out_ready;
      done = 1'b0;
      if (clear) begin
        bits.delete();
        m_ovr = 1'b0;
      end else if (shift_en) begin
        bits.push_back(in);
        if (bits.size() == W) begin
          done = 1'b1;
          wm = '0;
          wl = '0;
          for (int i = 0; i < W; i++) begin
            wm = (wm << 1) | W'(bits[i]);
            wl[i] = bits[i];
          end
          bits.delete();
        end
      end
      if (done) begin
        if (!m_valid || hs) begin
          q_m.push_back(wm);
          q_l.push_back(wl);
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (hs) begin
        m_valid = 1'b0;
      end
    end
  end

  // Monitor: flags every cycle, presented word against the queue head.
  always @(negedge clk) begin
    chk("valid_msb", valid_m, m_valid);
    chk("valid_lsb", valid_l, m_valid);
    chk("busy_msb", busy_m, bits.size() != 0);
    chk("busy_lsb", busy_l, bits.size() != 0);
    chk("ovr_msb", ovr_m, m_ovr);
    chk("ovr_lsb", ovr_l, m_ovr);
    if (valid_m) begin
      if (q_m.size() == 0 || q_l.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL word_present actual=valid expected=no_word at %0t", $time);
      end else begin
        chk("word_msb", out_m, q_m[0]);
        chk("word_lsb", out_l, q_l[0]);
        if (out_ready) begin
          void'(q_m.pop_front());
          void'(q_l.pop_front());
        end
      end
    end
  end

  task automatic step(input logic se, input logic b, input logic rdy, input logic clr);
    in = b;
    shift_en = se;
    out_ready = rdy;
    clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [3:0] w, input logic rdy);
    for (int i = 3; i >= 0; i--) step(1'b1, w[i], rdy, 1'b0);
  endtask

  task automatic drain();
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [3:0] pat;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out_m, 4'b0000);
    chk("rst_valid", valid_m, 1'b0);
    chk("rst_busy", busy_m, 1'b0);
    chk("rst_ovr", ovr_m, 1'b0);
    rst = 1'b0;

    // word capture
    pat = 4'b1010;
    send4(pat, 1'b0);
    chk("cap_out", out_m, 4'b1010);
    chk("cap_lsb_out", out_l, 4'b0101);
    chk("cap_valid", valid_m, 1'b1);
    drain();

    // back-to-back with gaps
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("b2b_first", out_m, 4'b1100);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("b2b_one_cycle", valid_m, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("b2b_second", out_m, 4'b0111);
    chk("b2b_ovr", ovr_m, 1'b0);
    drain();

    // overrun
    pat = 4'b1010;
    send4(pat, 1'b0);
    pat = 4'b0101;
    send4(pat, 1'b0);
    chk("ovr_out_kept", out_m, 4'b1010);
    chk("ovr_set", ovr_m, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_cleared", ovr_m, 1'b0);
    chk("ovr_valid_kept", valid_m, 1'b1);
    drain();

    // clear mid-word
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    pat = 4'b0011;
    send4(pat, 1'b0);
    chk("clr_out", out_m, 4'b0011);
    drain();

    // LSB-first
    pat = 4'b1000;
    send4(pat, 1'b0);
    chk("lsb_out", out_l, 4'b0001);
    chk("lsb_msb_twin", out_m, 4'b1000);
    drain();

    // reset mid-word, between edges
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy_m, 1'b0);
    chk("arst_valid", valid_m, 1'b0);
    chk("arst_out", out_m, 4'b0000);
    chk("arst_ovr", ovr_m, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pat = 4'b1001;
    send4(pat, 1'b0);
    chk("post_rst_out", out_m, 4'b1001);
    drain();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 24) == 0));
    end
    drain();
    chk("final_q_msb", q_m.size(), 0);
    chk("final_q_lsb", q_l.size(), 0);
    chk("final_valid", valid_m, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
